// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - op codes, FSM states and select helpers for the ALU op controller
package alu_ctrl_pkg;

  localparam logic [2:0] OP_ADD     = 3'd0;
  localparam logic [2:0] OP_SUB     = 3'd1;
  localparam logic [2:0] OP_MULT    = 3'd2;
  localparam logic [2:0] OP_AND     = 3'd3;
  localparam logic [2:0] OP_OR      = 3'd4;
  localparam logic [2:0] OP_COMPARE = 3'd5;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_LATCH   = 2'd1;
  localparam logic [1:0] S_EXEC    = 2'd2;
  localparam logic [1:0] S_CONVERT = 2'd3;

  // Select and request vectors are ordered {sub, mult, and, or, compare}; ADD has no select.
  function automatic logic [4:0] op_to_sel(input logic [2:0] op);
    case (op)
      OP_SUB:     op_to_sel = 5'b10000;
      OP_MULT:    op_to_sel = 5'b01000;
      OP_AND:     op_to_sel = 5'b00100;
      OP_OR:      op_to_sel = 5'b00010;
      OP_COMPARE: op_to_sel = 5'b00001;
      default:    op_to_sel = 5'b00000;
    endcase
  endfunction

  function automatic logic [2:0] req_to_op(input logic [4:0] req);
    if (req[4])      req_to_op = OP_SUB;
    else if (req[3]) req_to_op = OP_MULT;
    else if (req[2]) req_to_op = OP_AND;
    else if (req[1]) req_to_op = OP_OR;
    else if (req[0]) req_to_op = OP_COMPARE;
    else             req_to_op = OP_ADD;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - counter debouncer with a one-cycle rising-edge pulse
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_level,
  output logic o_rise
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Any sample agreeing with the current level restarts the stability window.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_level <= 1'b0;
      o_rise  <= 1'b0;
      cnt     <= '0;
    end else begin
      o_rise <= 1'b0;
      if (i_btn == o_level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        o_level <= i_btn;
        o_rise  <= i_btn;
        cnt     <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/alu_op_controller.sv
// rtl/alu_op_controller.sv - conditions board inputs and sequences ALU evaluation then BCD conversion
module alu_op_controller
  import alu_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int ALU_LATENCY     = 1,
  parameter int BCD_TIMEOUT     = 64
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_dataIn,
  input  logic       i_btnSub,
  input  logic       i_btnMult,
  input  logic       i_btnAnd,
  input  logic       i_btnOr,
  input  logic       i_btnCompare,
  input  logic [7:0] i_aluResult,
  input  logic       i_bcdDone,
  output logic [3:0] o_A,
  output logic [3:0] o_B,
  output logic       o_Sub,
  output logic       o_Mult,
  output logic       o_And,
  output logic       o_Or,
  output logic       o_Compare,
  output logic       o_bcdStart,
  output logic [7:0] o_result,
  output logic [2:0] o_opCode,
  output logic       o_busy,
  output logic       o_timeout
);

  localparam int EW = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;
  localparam int TW = (BCD_TIMEOUT > 1) ? $clog2(BCD_TIMEOUT) : 1;
  localparam logic [EW-1:0] EXEC_LAST = EW'(ALU_LATENCY - 1);
  localparam logic [TW-1:0] WAIT_LAST = TW'(BCD_TIMEOUT - 1);

  logic [4:0] btn_meta, btn_sync, btn_level, btn_rise, req;
  logic [7:0] sw_meta, sw_sync;
  logic [3:0] sw_a, sw_b;

  // Switches are active-low, so their synchronisers reset to the all-released pattern.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      btn_meta <= '0;
      btn_sync <= '0;
      sw_meta  <= 8'hFF;
      sw_sync  <= 8'hFF;
    end else begin
      btn_meta <= {i_btnSub, i_btnMult, i_btnAnd, i_btnOr, i_btnCompare};
      btn_sync <= btn_meta;
      sw_meta  <= i_dataIn;
      sw_sync  <= sw_meta;
    end
  end

  assign sw_a = ~{sw_sync[0], sw_sync[1], sw_sync[2], sw_sync[3]};
  assign sw_b = ~{sw_sync[4], sw_sync[5], sw_sync[6], sw_sync[7]};

  for (genvar i = 0; i < 5; i++) begin : g_deb
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_btn  (btn_sync[i]),
      .o_level(btn_level[i]),
      .o_rise (btn_rise[i])
    );
  end

  assign req = btn_rise & btn_level;

  logic [1:0]    state;
  logic [EW-1:0] exec_cnt;
  logic [TW-1:0] wait_cnt;
  logic [7:0]    alu_capture;

  assign o_busy = (state != S_IDLE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= S_IDLE;
      exec_cnt    <= '0;
      wait_cnt    <= '0;
      alu_capture <= '0;
      o_A         <= '0;
      o_B         <= '0;
      {o_Sub, o_Mult, o_And, o_Or, o_Compare} <= '0;
      o_bcdStart  <= 1'b0;
      o_result    <= '0;
      o_opCode    <= OP_ADD;
      o_timeout   <= 1'b0;
    end else begin
      o_bcdStart <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|req) begin
            o_opCode <= req_to_op(req);
            state    <= S_LATCH;
          end else if ((sw_a != o_A) || (sw_b != o_B)) begin
            state <= S_LATCH;
          end
        end
        S_LATCH: begin
          o_A      <= sw_a;
          o_B      <= sw_b;
          {o_Sub, o_Mult, o_And, o_Or, o_Compare} <= op_to_sel(o_opCode);
          exec_cnt <= '0;
          state    <= S_EXEC;
        end
        S_EXEC: begin
          if (exec_cnt == EXEC_LAST) begin
            alu_capture <= i_aluResult;
            o_bcdStart  <= 1'b1;
            wait_cnt    <= '0;
            state       <= S_CONVERT;
          end else begin
            exec_cnt <= exec_cnt + EW'(1);
          end
        end
        S_CONVERT: begin
          if (i_bcdDone) begin
            o_result  <= alu_capture;
            o_timeout <= 1'b0;
            state     <= S_IDLE;
          end else if (wait_cnt == WAIT_LAST) begin
            o_timeout <= 1'b1;
            state     <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_controller.sv
// tb/tb_alu_op_controller.sv - directed and randomized checks of alu_op_controller against a reference model
module tb_alu_op_controller;

  localparam int DEB = 4;
  localparam int ALU_LAT = 1;
  localparam int BCD_TO = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] data_in;
  logic       btn_sub, btn_mult, btn_and, btn_or, btn_cmp;
  logic [7:0] alu_result;
  logic       bcd_done;
  logic [3:0] o_A, o_B;
  logic       o_Sub, o_Mult, o_And, o_Or, o_Compare;
  logic       o_bcdStart, o_busy, o_timeout;
  logic [7:0] o_result;
  logic [2:0] o_opCode;

  alu_op_controller #(
    .DEBOUNCE_CYCLES(DEB),
    .ALU_LATENCY    (ALU_LAT),
    .BCD_TIMEOUT    (BCD_TO)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_dataIn    (data_in),
    .i_btnSub    (btn_sub),
    .i_btnMult   (btn_mult),
    .i_btnAnd    (btn_and),
    .i_btnOr     (btn_or),
    .i_btnCompare(btn_cmp),
    .i_aluResult (alu_result),
    .i_bcdDone   (bcd_done),
    .o_A         (o_A),
    .o_B         (o_B),
    .o_Sub       (o_Sub),
    .o_Mult      (o_Mult),
    .o_And       (o_And),
    .o_Or        (o_Or),
    .o_Compare   (o_Compare),
    .o_bcdStart  (o_bcdStart),
    .o_result    (o_result),
    .o_opCode    (o_opCode),
    .o_busy      (o_busy),
    .o_timeout   (o_timeout)
  );

  int n_vec = 0;
  int n_bad = 0;
  int n_start = 0;

  logic [3:0] exp_a, exp_b;
  logic [2:0] exp_op;
  logic [7:0] exp_res, cur_sw;
  logic       exp_to;

  function automatic logic [7:0] alu_fn(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    logic [7:0] wa, wb;
    wa = {4'b0, a};
    wb = {4'b0, b};
    case (op)
      3'd1:    return wa - wb;
      3'd2:    return wa * wb;
      3'd3:    return wa & wb;
      3'd4:    return wa | wb;
      3'd5:    return {6'b0, a > b, a == b};
      default: return wa + wb;
    endcase
  endfunction

  // Stand-in ALU driven by the DUT's registered operands and selects.
  assign alu_result = alu_fn(o_A, o_B,
                             o_Sub ? 3'd1 : o_Mult ? 3'd2 : o_And ? 3'd3 :
                             o_Or ? 3'd4 : o_Compare ? 3'd5 : 3'd0);

  always @(negedge clk) if (o_bcdStart === 1'b1) n_start++;

  function automatic logic [3:0] sw_to_a(input logic [7:0] sw);
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[3-i] = ~sw[i];
    return v;
  endfunction

  function automatic logic [3:0] sw_to_b(input logic [7:0] sw);
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[3-i] = ~sw[4+i];
    return v;
  endfunction

  function automatic logic [4:0] sel_of(input logic [2:0] op);
    logic [4:0] v;
    v = '0;
    if (op >= 3'd1 && op <= 3'd5) v[5-int'(op)] = 1'b1;
    return v;
  endfunction

  function automatic logic [2:0] prio_op(input logic [4:0] mask);
    for (int i = 0; i < 5; i++) if (mask[4-i]) return 3'(i + 1);
    return 3'd0;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_btns(input logic [4:0] m);
    btn_sub  = m[4];
    btn_mult = m[3];
    btn_and  = m[2];
    btn_or   = m[1];
    btn_cmp  = m[0];
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_a = '0; exp_b = '0; exp_op = '0; exp_res = '0; exp_to = 1'b0; cur_sw = 8'hFF;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " A"}, 32'(o_A), 32'd0);
    check({tag, " B"}, 32'(o_B), 32'd0);
    check({tag, " sel"}, 32'({o_Sub, o_Mult, o_And, o_Or, o_Compare}), 32'd0);
    check({tag, " op"}, 32'(o_opCode), 32'd0);
    check({tag, " start"}, 32'(o_bcdStart), 32'd0);
    check({tag, " result"}, 32'(o_result), 32'd0);
    check({tag, " busy"}, 32'(o_busy), 32'd0);
    check({tag, " timeout"}, 32'(o_timeout), 32'd0);
  endtask

  // One operation: a button mask and/or a switch change, then a converter reply after `delay`
  // cycles, or none at all when `drop` is set. `busy_mask` is pressed while converting.
  task automatic do_op(input string tag, input logic [4:0] mask, input logic [7:0] sw,
                       input int delay, input bit drop, input logic [4:0] busy_mask);
    int  starts0, waited;
    bit  seen;
    starts0 = n_start;
    if (mask != 5'd0) exp_op = prio_op(mask);
    exp_a = sw_to_a(sw);
    exp_b = sw_to_b(sw);
    data_in = sw;
    cur_sw = sw;
    set_btns(mask);
    seen = 1'b0;
    for (waited = 0; waited < 40 && !seen; waited++) begin
      tick();
      if (o_bcdStart === 1'b1) seen = 1'b1;
    end
    check({tag, " start seen"}, 32'(seen), 32'd1);
    set_btns(5'd0);
    if (!seen) return;
    check({tag, " A"}, 32'(o_A), 32'(exp_a));
    check({tag, " B"}, 32'(o_B), 32'(exp_b));
    check({tag, " sel"}, 32'({o_Sub, o_Mult, o_And, o_Or, o_Compare}), 32'(sel_of(exp_op)));
    check({tag, " op"}, 32'(o_opCode), 32'(exp_op));
    check({tag, " busy hi"}, 32'(o_busy), 32'd1);
    if (drop) begin
      waited = 0;
      while (o_busy === 1'b1 && waited < BCD_TO + 8) begin
        tick();
        waited++;
        if (waited == 1) check({tag, " start width"}, 32'(o_bcdStart), 32'd0);
      end
      check({tag, " timeout cycles"}, 32'(waited), 32'(BCD_TO));
      exp_to = 1'b1;
    end else begin
      for (int k = 0; k < delay; k++) begin
        if (k == 0) set_btns(busy_mask);
        if (k == 8) set_btns(5'd0);
        tick();
        if (k == 0) check({tag, " start width"}, 32'(o_bcdStart), 32'd0);
      end
      bcd_done = 1'b1;
      tick();
      bcd_done = 1'b0;
      if (delay == 0) check({tag, " start width"}, 32'(o_bcdStart), 32'd0);
      exp_res = alu_fn(exp_a, exp_b, exp_op);
      exp_to = 1'b0;
    end
    set_btns(5'd0);
    check({tag, " busy lo"}, 32'(o_busy), 32'd0);
    check({tag, " result"}, 32'(o_result), 32'(exp_res));
    check({tag, " timeout"}, 32'(o_timeout), 32'(exp_to));
    repeat (12) tick();
    check({tag, " idle after"}, 32'(o_busy), 32'd0);
    check({tag, " one start"}, 32'(n_start - starts0), 32'd1);
    check({tag, " op held"}, 32'(o_opCode), 32'(exp_op));
  endtask

  initial begin
    int starts0, r, dly;
    bit seen;
    logic [7:0] nsw;
    logic [4:0] m;

    rst = 1'b1;
    data_in = 8'hFF;
    bcd_done = 1'b0;
    set_btns(5'd0);
    model_reset();
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    repeat (6) tick();
    check("post-reset idle", 32'(o_busy), 32'd0);

    do_op("add", 5'd0, 8'b1111_0011, 5, 1'b0, 5'd0);
    check("add result const", 32'(o_result), 32'd3);
    check("add A const", 32'(o_A), 32'd3);

    starts0 = n_start;
    for (int i = 0; i < 2; i++) begin
      btn_mult = 1'b1; repeat (2) tick();
      btn_mult = 1'b0; repeat (2) tick();
    end
    repeat (4) tick();
    check("bounce no op", 32'(n_start - starts0), 32'd0);
    do_op("mult", 5'b01000, cur_sw, 3, 1'b0, 5'd0);
    check("mult op const", 32'(o_opCode), 32'd2);
    check("mult sel const", 32'(o_Mult), 32'd1);

    do_op("sub+or", 5'b10010, cur_sw, 2, 1'b0, 5'd0);
    check("simul sub", 32'(o_Sub), 32'd1);
    check("simul or", 32'(o_Or), 32'd0);
    check("simul op", 32'(o_opCode), 32'd1);

    do_op("busy drop", 5'd0, 8'b1110_0011, 12, 1'b0, 5'b00100);
    check("busy drop op", 32'(o_opCode), 32'd1);
    check("busy drop result", 32'(o_result), 32'hFB);

    do_op("timeout", 5'd0, 8'b1111_0011, 0, 1'b1, 5'd0);
    check("timeout retain", 32'(o_result), 32'hFB);
    do_op("recover", 5'd0, 8'b0111_0011, 4, 1'b0, 5'd0);
    check("recover clear", 32'(o_timeout), 32'd0);

    starts0 = n_start;
    data_in = 8'b0011_1100;
    seen = 1'b0;
    for (int w = 0; w < 10 && !seen; w++) begin
      tick();
      if (o_busy === 1'b1) seen = 1'b1;
    end
    check("rst run busy", 32'(seen), 32'd1);
    tick();
    rst = 1'b1;
    data_in = 8'hFF;
    tick();
    check("rst first edge busy", 32'(o_busy), 32'd0);
    repeat (2) tick();
    check_all_zero("mid-exec reset");
    rst = 1'b0;
    model_reset();
    repeat (12) tick();
    check("rst no restart", 32'(o_busy), 32'd0);
    check("rst no start", 32'(n_start - starts0), 32'd0);

    for (int it = 0; it < 30; it++) begin
      r = int'($urandom_range(0, 7));
      dly = int'($urandom_range(0, 10));
      if (r < 4) begin
        m = 5'($urandom_range(1, 31));
        do_op("rand btn", m, cur_sw, dly, 1'b0, 5'd0);
      end else begin
        nsw = 8'($urandom);
        if (sw_to_a(nsw) == exp_a && sw_to_b(nsw) == exp_b) nsw[0] = ~nsw[0];
        do_op("rand sw", 5'd0, nsw, dly, ($urandom_range(0, 9) == 0), 5'd0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
